digit_scan_driver: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Sits directly upstream of the 7-segment decoder (inputs En, A3..A0):
  - nibble drives A3..A0.
  - seg_en drives En.
  - dp_out feeds the DP segment path.
  - dig_sel drives the digit anode transistors.
- Holds a double-buffered display value. New values apply only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/digit_scan_driver.sv | 149 ++++++++++++++
 tb/tb_digit_scan_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_driver.sv
// digit_scan_driver: time-multiplexed scan controller for an N-digit
// common-anode 7-segment display, feeding a hex decoder (En, A3..A0).
// The displayed value is double-buffered so that a frame never mixes
// old and new digits; a loaded value only takes effect at a frame boundary.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above digit 0 whose nibble and every higher nibble
//   are zero have the decoder disabled during their slot. Digit selection
//   timing is unaffected and digit 0 always shows.
module digit_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_load,
  input  logic [4*NUM_DIGITS-1:0]   i_value_in,
  input  logic [NUM_DIGITS-1:0]     i_dp_in,
  output logic [3:0]                o_nibble,
  output logic                      o_seg_en,
  output logic                      o_dp_out,
  output logic [NUM_DIGITS-1:0]     o_dig_sel,
  output logic                      o_busy,
  output logic                      o_load_ack
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_shd_val;
  logic [NUM_DIGITS-1:0]   r_shd_dp;
  logic                    r_pending;
  logic                    r_load_ack;

  logic                    w_tick;
  logic                    w_frame_end;
  logic                    w_blank;
  logic                    w_suppress;
  logic [3:0]              w_nibble;
  logic                    w_dp_sel;
  logic [NUM_DIGITS-1:0]   w_dig_sel;
  logic                    w_seg_en;

  assign w_tick      = (r_cnt == CNT_MAX);
  assign w_frame_end = w_tick && (r_idx == IDX_MAX);

  // The anti-ghosting window is removed entirely when it has zero length,
  // avoiding a comparison against zero that would be constant-false.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  // Slot timing: cnt counts cycles inside a slot, idx walks the digits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Double buffer: loads land in the shadow, and only a frame boundary
  // promotes a value to the display; a load on the boundary goes straight in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_shd_val  <= '0;
      r_shd_dp   <= '0;
      r_pending  <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      r_load_ack <= 1'b0;
      if (i_load && w_frame_end) begin
        r_disp_val <= i_value_in;
        r_disp_dp  <= i_dp_in;
        r_pending  <= 1'b0;
        r_load_ack <= 1'b1;
      end else if (i_load) begin
        r_shd_val  <= i_value_in;
        r_shd_dp   <= i_dp_in;
        r_pending  <= 1'b1;
      end else if (w_frame_end && r_pending) begin
        r_disp_val <= r_shd_val;
        r_disp_dp  <= r_shd_dp;
        r_pending  <= 1'b0;
        r_load_ack <= 1'b1;
      end
    end
  end

  // Select the scanned digit's nibble, decimal point and active-low anode.
  always_comb begin
    w_nibble  = 4'h0;
    w_dp_sel  = 1'b0;
    w_dig_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble = r_disp_val[4*i +: 4];
        w_dp_sel = r_disp_dp[i];
        w_dig_sel[i] = w_blank;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_zero_run;

  // Walk from the top digit down; a digit is a leading zero while every
  // nibble from the top through it is zero. Digit 0 is never suppressed.
  always_comb begin
    w_zero_run = 1'b1;
    w_suppress = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_run = w_zero_run && (r_disp_val[4*i +: 4] == 4'h0);
      if (r_idx == IW'(i)) begin
        w_suppress = w_zero_run;
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  assign w_seg_en = ~w_blank & ~w_suppress;

  assign o_nibble   = w_nibble;
  assign o_seg_en   = w_seg_en;
  assign o_dp_out   = w_dp_sel & w_seg_en;
  assign o_dig_sel  = w_dig_sel;
  assign o_busy     = r_pending;
  assign o_load_ack = r_load_ack;

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver: directed bench for digit_scan_driver with
// NUM_DIGITS=4, SCAN_DIV=8. Two instances share the stimulus: one with
// BLANK_CYCLES=2 and one with BLANK_CYCLES=0. Honours LEADING_ZERO_BLANK_EN.
module tb_digit_scan_driver;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int NS = N * S;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;

  logic [3:0] nibbleA, selA;
  logic       segA, dpA, busyA, ackA;
  logic [3:0] nibbleB, selB;
  logic       segB, dpB, busyB, ackB;

  int checkCount;
  int passCount;
  int t;
  logic sawAllOnesB;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [3:0]  dp;
  } loadRec_t;

  loadRec_t loadQ[$];

  digit_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(2)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value_in(value_in),
    .i_dp_in(dp_in), .o_nibble(nibbleA), .o_seg_en(segA), .o_dp_out(dpA),
    .o_dig_sel(selA), .o_busy(busyA), .o_load_ack(ackA)
  );

  digit_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(0)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value_in(value_in),
    .i_dp_in(dp_in), .o_nibble(nibbleB), .o_seg_en(segB), .o_dp_out(dpB),
    .o_dig_sel(selB), .o_busy(busyB), .o_load_ack(ackB)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               name, t, actual, expected);
    end
  endtask

  // Reference behaviour expressed in cycles since reset: the display shows
  // the latest load made before the current frame started.
  function automatic void modelAt(input int tc, input int blankCyc,
                                  output logic [3:0] nib, output logic seg,
                                  output logic dp, output logic [3:0] sel,
                                  output logic busyE, output logic ackE);
    int frameStart;
    int digit;
    int off;
    logic [15:0] v;
    logic [15:0] shifted;
    logic [3:0]  d;
    logic blank;
    logic suppress;
    frameStart = (tc / NS) * NS;
    digit = (tc / S) % N;
    off = tc % S;
    v = '0;
    d = '0;
    busyE = 1'b0;
    ackE = 1'b0;
    foreach (loadQ[k]) begin
      if (loadQ[k].cyc < frameStart) begin
        v = loadQ[k].val;
        d = loadQ[k].dp;
      end
      if (loadQ[k].cyc >= frameStart && loadQ[k].cyc < tc) busyE = 1'b1;
      if (tc > 0 && (tc % NS) == 0 && loadQ[k].cyc >= tc - NS && loadQ[k].cyc < tc)
        ackE = 1'b1;
    end
    blank = (off < blankCyc);
    sel = blank ? 4'hF : ~(4'b0001 << digit);
    shifted = v >> (4 * digit);
    nib = shifted[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    suppress = (digit > 0) && (shifted == 16'h0);
`else
    suppress = 1'b0;
`endif
    seg = !blank && !suppress;
    dp = d[digit] & seg;
  endfunction

  // Model timekeeping: count cycles since reset and log every sampled load.
  always @(posedge clk or negedge rst_n) begin
    loadRec_t rec;
    if (!rst_n) begin
      t <= 0;
      loadQ.delete();
    end else begin
      if (load) begin
        rec.cyc = t;
        rec.val = value_in;
        rec.dp  = dp_in;
        loadQ.push_back(rec);
      end
      t <= t + 1;
    end
  end

  // Compare both instances against the model on every falling edge out of reset.
  always @(negedge clk) begin
    logic [3:0] eNib, eSel;
    logic eSeg, eDp, eBusy, eAck;
    if (rst_n) begin
      modelAt(t, 2, eNib, eSeg, eDp, eSel, eBusy, eAck);
      checkOutput("A_nibble", nibbleA, eNib);
      checkOutput("A_seg_en", segA, eSeg);
      checkOutput("A_dp_out", dpA, eDp);
      checkOutput("A_dig_sel", selA, eSel);
      checkOutput("A_busy", busyA, eBusy);
      checkOutput("A_load_ack", ackA, eAck);
      modelAt(t, 0, eNib, eSeg, eDp, eSel, eBusy, eAck);
      checkOutput("B_nibble", nibbleB, eNib);
      checkOutput("B_seg_en", segB, eSeg);
      checkOutput("B_dp_out", dpB, eDp);
      checkOutput("B_dig_sel", selB, eSel);
      checkOutput("B_busy", busyB, eBusy);
      checkOutput("B_load_ack", ackB, eAck);
      if (selB == 4'hF) sawAllOnesB = 1'b1;
    end
  end

  task automatic finishRun();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  endtask

  task automatic waitCycle(input int target);
    int guard;
    guard = 0;
    while (t != target) begin
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        checkCount++;
        $display("[TB] FAIL wait_timeout: reached cycle %0d, expected %0d", t, target);
        finishRun();
      end
    end
  endtask

  task automatic applyStimulus(input int atCycle, input logic [15:0] val,
                               input logic [3:0] dp);
    waitCycle(atCycle);
    load = 1'b1;
    value_in = val;
    dp_in = dp;
    @(negedge clk);
    load = 1'b0;
    value_in = 16'hDEAD;
    dp_in = 4'b1010;
  endtask

  // Directed sequence with hand-computed literal expectations.
  initial begin
    checkCount = 0;
    passCount = 0;
    sawAllOnesB = 1'b0;
    rst_n = 1'b0;
    load = 1'b0;
    value_in = 16'h0;
    dp_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_sel_A", selA, 4'hF);
    checkOutput("rst_seg_A", segA, 1'b0);
    checkOutput("rst_nib_A", nibbleA, 4'h0);
    checkOutput("rst_busy_A", busyA, 1'b0);
    checkOutput("rst_ack_A", ackA, 1'b0);
    checkOutput("rst_dp_A", dpA, 1'b0);
    checkOutput("rst_sel_B", selB, 4'hE);
    checkOutput("rst_seg_B", segB, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    waitCycle(0);  checkOutput("free_sel_t0", selA, 4'hF);
    waitCycle(2);  checkOutput("free_sel_t2", selA, 4'hE);
    waitCycle(9);  checkOutput("free_sel_t9", selA, 4'hF);
    waitCycle(10); checkOutput("free_sel_t10", selA, 4'hD);
    waitCycle(26); checkOutput("free_sel_t26", selA, 4'h7);
    checkOutput("free_nib_t26", nibbleA, 4'h0);

    applyStimulus(67, 16'h12AF, 4'b0100);
    waitCycle(68);  checkOutput("ld_busy_68", busyA, 1'b1);
    waitCycle(95);  checkOutput("ld_busy_95", busyA, 1'b1);
    checkOutput("ld_ack_95", ackA, 1'b0);
    waitCycle(96);  checkOutput("ld_ack_96", ackA, 1'b1);
    checkOutput("ld_busy_96", busyA, 1'b0);
    waitCycle(97);  checkOutput("ld_ack_97", ackA, 1'b0);
    waitCycle(98);  checkOutput("ld_nib_d0", nibbleA, 4'hF);
    checkOutput("ld_dp_d0", dpA, 1'b0);
    waitCycle(106); checkOutput("ld_nib_d1", nibbleA, 4'hA);
    waitCycle(112); checkOutput("ld_dp_blank", dpA, 1'b0);
    waitCycle(114); checkOutput("ld_nib_d2", nibbleA, 4'h2);
    checkOutput("ld_dp_d2", dpA, 1'b1);
    waitCycle(122); checkOutput("ld_nib_d3", nibbleA, 4'h1);

    applyStimulus(130, 16'h1111, 4'h0);
    applyStimulus(140, 16'h2222, 4'h0);
    waitCycle(159); checkOutput("dbl_ack_159", ackA, 1'b0);
    waitCycle(160); checkOutput("dbl_ack_160", ackA, 1'b1);
    waitCycle(161); checkOutput("dbl_ack_161", ackA, 1'b0);
    waitCycle(162); checkOutput("dbl_nib_d0", nibbleA, 4'h2);

    applyStimulus(191, 16'hBEEF, 4'h0);
    checkOutput("fe_busy_192", busyA, 1'b0);
    checkOutput("fe_ack_192", ackA, 1'b1);
    waitCycle(194); checkOutput("fe_nib_d0", nibbleA, 4'hF);
    waitCycle(202); checkOutput("fe_nib_d1", nibbleA, 4'hE);
    waitCycle(210); checkOutput("fe_nib_d2", nibbleA, 4'hE);
    waitCycle(218); checkOutput("fe_nib_d3", nibbleA, 4'hB);

    applyStimulus(230, 16'h5555, 4'hF);
    waitCycle(235); checkOutput("mid_busy_pre", busyA, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_sel", selA, 4'hF);
    checkOutput("mid_busy", busyA, 1'b0);
    checkOutput("mid_ack", ackA, 1'b0);
    checkOutput("mid_nib", nibbleA, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(5, 16'h0070, 4'b0011);
    waitCycle(34); checkOutput("lz_nib_d0", nibbleA, 4'h0);
    checkOutput("lz_seg_d0", segA, 1'b1);
    checkOutput("lz_dp_d0", dpA, 1'b1);
    waitCycle(42); checkOutput("lz_nib_d1", nibbleA, 4'h7);
    checkOutput("lz_seg_d1", segA, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    waitCycle(50); checkOutput("lz_seg_d2", segA, 1'b0);
    checkOutput("lz_sel_d2", selA, 4'hB);
    waitCycle(58); checkOutput("lz_seg_d3", segA, 1'b0);
    checkOutput("lz_segB_d3", segB, 1'b0);
`else
    waitCycle(50); checkOutput("lz_seg_d2", segA, 1'b1);
    checkOutput("lz_sel_d2", selA, 4'hB);
    waitCycle(58); checkOutput("lz_seg_d3", segA, 1'b1);
    checkOutput("lz_segB_d3", segB, 1'b1);
`endif
    waitCycle(64);
    checkOutput("B_never_all_ones", sawAllOnesB, 1'b0);
    finishRun();
  end

endmodule
